// File: rtl/data_mem_ctrl_if.sv
// Data-memory access bus between the datapath and data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int unsigned AW = 7
);
  logic [AW-1:0] Addr;
  logic [31:0]   DataIn;
  logic          MemWR;
  logic          MemRD;
  logic [1:0]    Size;
  logic          Unsigned;
  logic [31:0]   DataOut;
  logic          RdValid;
  logic          AlignErr;
  logic          Busy;

  // Datapath side: issues requests, consumes load results.
  modport master (
    output Addr, DataIn, MemWR, MemRD, Size, Unsigned,
    input  DataOut, RdValid, AlignErr, Busy
  );

  // Memory side: serves requests, returns load results.
  modport slave (
    input  Addr, DataIn, MemWR, MemRD, Size, Unsigned,
    output DataOut, RdValid, AlignErr, Busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with sign/zero-extending loads, misalignment
// detection, optional registered read path and post-reset sequential clear.
module data_mem_ctrl #(
  parameter int unsigned AW             = 7,
  parameter int unsigned RD_REG         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic           Clk,
  input  logic           Rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned WA    = AW - 2;
  localparam int unsigned DEPTH = 1 << WA;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [0:0]    state_q, state_d;
  logic [WA-1:0] clr_ptr_q, clr_ptr_d;
  logic          clr_we;

  logic [31:0]   mem_q [DEPTH];

  logic [WA-1:0] word_idx;
  logic [1:0]    lane;
  logic          idle;
  logic          rd_req;
  logic          wr_en;
  logic          align_err_c;
  logic          acc_err_c;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          sext;
  logic [31:0]   load_c;
  logic [31:0]   dout_c;

  logic [31:0]   dout_q, dout_d;
  logic          rd_valid_q, rd_valid_d;
  logic          align_err_q, align_err_d;

  assign word_idx = bus.Addr[AW-1:2];
  assign lane     = bus.Addr[1:0];
  assign idle     = (state_q == S_IDLE);
  assign rd_req   = idle & bus.MemRD;
  assign wr_en    = idle & bus.MemWR & ~align_err_c;
  assign acc_err_c = idle & (bus.MemRD | bus.MemWR) & align_err_c;
  assign rd_word  = mem_q[word_idx];
  assign sext     = ~bus.Unsigned;

  // State and clear-pointer registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_RESET;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next-state: walk the clear pointer over every word, then go idle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + WA'(1);
        if (clr_ptr_q == '1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Size decode: alignment check, lane enables and lane-replicated store data.
  always_comb begin
    align_err_c = 1'b0;
    be_c        = 4'b0000;
    wdata_c     = '0;
    case (bus.Size)
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{bus.DataIn[7:0]}};
      end
      2'b01: begin
        align_err_c = lane[0];
        be_c        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c     = {2{bus.DataIn[15:0]}};
      end
      2'b10: begin
        align_err_c = (lane != 2'b00);
        be_c        = 4'b1111;
        wdata_c     = bus.DataIn;
      end
      default: begin
        align_err_c = 1'b1;
      end
    endcase
  end

  // Array write port: clear has priority; stores only touch enabled lanes.
  always_ff @(posedge Clk) begin
    if (clr_we) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be_c[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_c[8*k +: 8];
        end
      end
    end
  end

  // Load field select and extension; misaligned loads return zero.
  always_comb begin
    case (lane)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_c   = '0;
    if (!align_err_c) begin
      case (bus.Size)
        2'b00:   load_c = {{24{sext & byte_sel[7]}}, byte_sel};
        2'b01:   load_c = {{16{sext & half_sel[15]}}, half_sel};
        2'b10:   load_c = rd_word;
        default: load_c = '0;
      endcase
    end
  end

  // Combinational-read result: zero when no load is in flight.
  always_comb begin
    dout_c = '0;
    if (rd_req) begin
      dout_c = load_c;
    end
  end

  // Registered-read next values: data holds between loads, flags pulse.
  always_comb begin
    dout_d      = dout_q;
    rd_valid_d  = rd_req;
    align_err_d = acc_err_c;
    if (rd_req) begin
      dout_d = load_c;
    end
  end

  // Registered-read output flops.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      rd_valid_q  <= rd_valid_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.Busy     = (state_q == S_CLEAR);
  assign bus.DataOut  = (RD_REG != 0) ? dout_q      : dout_c;
  assign bus.RdValid  = (RD_REG != 0) ? rd_valid_q  : rd_req;
  assign bus.AlignErr = (RD_REG != 0) ? align_err_q : acc_err_c;

endmodule
